// File: rtl/test_value_display.sv
// test_value_display: shows a filtered 16-bit value as hex on a multiplexed 4-digit seven-segment display
module test_value_display #(
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_CYCLES = 4,
    parameter bit BLANK_LZ    = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] test_value,
    input  logic        FREEZE,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic [3:0]  AN
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [PW-1:0] PRE_MAX  = PW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic [15:0]   prev_val, disp_val;
    logic [HW-1:0] stab_cnt;
    logic [PW-1:0] pre;
    logic [1:0]    digit;
    logic [3:0]    nib;
    logic          blank;
    always_comb begin
        nib   = 4'(disp_val >> {digit, 2'b00});
        blank = BLANK_LZ && digit != 2'd0 && (disp_val >> {digit, 2'b00}) == 16'h0;
    end
    always_ff @(posedge CLK) begin
        if (!RST) begin
            prev_val <= '0;
            disp_val <= '0;
            stab_cnt <= '0;
            pre      <= '0;
            digit    <= '0;
            AN       <= 4'b1110;
            SEG      <= 7'h40;
            DP       <= 1'b1;
        end else begin
            if (test_value != prev_val) begin
                prev_val <= test_value;
                stab_cnt <= '0;
            end else if (stab_cnt < HOLD_MAX) begin
                stab_cnt <= stab_cnt + 1'b1;
            end else if (!FREEZE) begin
                disp_val <= prev_val;
            end
            pre   <= pre == PRE_MAX ? '0 : pre + 1'b1;
            digit <= pre == PRE_MAX ? digit + 2'd1 : digit;
            SEG   <= SEG_LUT[nib];
            AN    <= blank ? 4'hF : ~(4'b0001 << digit);
            DP    <= !(digit == 2'd0 && FREEZE);
        end
    end
endmodule

// File: tb/tb_test_value_display.sv
// tb_test_value_display: directed + random stimulus against a sample-history reference model
module tb_test_value_display;
    localparam int SCAN = 4;
    localparam int HOLD = 3;
    logic        CLK = 0;
    logic        RST = 0;
    logic [15:0] test_value = 16'h1234;
    logic        FREEZE = 0;
    logic [6:0]  SEG, SEG0;
    logic        DP, DP0;
    logic [3:0]  AN, AN0;
    int checks = 0;
    int errors = 0;
    test_value_display #(.SCAN_DIV(SCAN), .HOLD_CYCLES(HOLD), .BLANK_LZ(1)) dut (
        .CLK(CLK), .RST(RST), .test_value(test_value), .FREEZE(FREEZE),
        .SEG(SEG), .DP(DP), .AN(AN)
    );
    test_value_display #(.SCAN_DIV(SCAN), .HOLD_CYCLES(HOLD), .BLANK_LZ(0)) dut_nb (
        .CLK(CLK), .RST(RST), .test_value(test_value), .FREEZE(FREEZE),
        .SEG(SEG0), .DP(DP0), .AN(AN0)
    );
    always #5 CLK = ~CLK;
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    // Model: the display takes a value once the last HOLD+1 samples agree; reset counts as one sample of 0.
    logic [15:0] hist[$];
    logic [15:0] m_disp;
    int          m_t;
    int          d;
    bit          same;
    logic [6:0]  e_seg;
    logic [3:0]  e_an, e_an0;
    logic        e_dp;
    always @(posedge CLK) begin
        if (!RST) begin
            hist = {};
            hist.push_back(16'h0);
            m_disp = 16'h0;
            m_t = 0;
            e_seg = 7'h40;
            e_an = 4'b1110;
            e_an0 = 4'b1110;
            e_dp = 1'b1;
        end else begin
            d = (m_t / SCAN) % 4;
            e_seg = lut[(m_disp >> (4 * d)) & 16'hF];
            e_an0 = ~(4'b0001 << d);
            e_an = (d != 0 && (m_disp >> (4 * d)) == 16'h0) ? 4'hF : e_an0;
            e_dp = !(d == 0 && FREEZE);
            hist.push_back(test_value);
            if (hist.size() > HOLD + 1) void'(hist.pop_front());
            same = 1;
            foreach (hist[i]) if (hist[i] != test_value) same = 0;
            if (hist.size() == HOLD + 1 && same && !FREEZE) m_disp = test_value;
            m_t++;
        end
    end
    bit armed = 0, in_glitch = 0, saw_ffff = 0, lit23 = 0, in_freeze = 0, saw_dp0 = 0;
    always @(negedge CLK) if (armed) begin
        check("seg", 16'(SEG), 16'(e_seg));
        check("an", 16'(AN), 16'(e_an));
        check("dp", 16'(DP), 16'(e_dp));
        check("seg_nb", 16'(SEG0), 16'(e_seg));
        check("an_nb", 16'(AN0), 16'(e_an0));
        check("dp_nb", 16'(DP0), 16'(e_dp));
        check("disp", dut.disp_val, m_disp);
        if (in_glitch && dut.disp_val == 16'hFFFF) saw_ffff = 1;
        if (in_glitch && (AN == 4'b1011 || AN == 4'b0111)) lit23 = 1;
        if (in_freeze && DP == 1'b0) saw_dp0 = 1;
    end
    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask
    initial begin
        logic [15:0] masks [4] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F};
        logic [15:0] sweep [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        bit hit;
        @(posedge CLK);
        #1 armed = 1;
        step(2);
        check("reset_an", 16'(AN), 16'h000E);
        check("reset_seg", 16'(SEG), 16'h0040);
        RST = 1;
        step(40);
        check("after_reset_disp", dut.disp_val, 16'h1234);
        test_value = 16'h00A5;
        step(20);
        in_glitch = 1;
        test_value = 16'hFFFF;
        step(2);
        test_value = 16'h00A5;
        step(30);
        in_glitch = 0;
        check("glitch_no_ffff", 16'(saw_ffff), 16'h0);
        check("glitch_no_lit23", 16'(lit23), 16'h0);
        check("glitch_disp", dut.disp_val, 16'h00A5);
        test_value = 16'h0000;
        step(30);
        test_value = 16'hBEEF;
        step(20);
        FREEZE = 1;
        in_freeze = 1;
        test_value = 16'h0001;
        step(10);
        check("freeze_hold", dut.disp_val, 16'hBEEF);
        step(10);
        check("freeze_dp0", 16'(saw_dp0), 16'h1);
        in_freeze = 0;
        FREEZE = 0;
        step(1);
        check("unfreeze_load", dut.disp_val, 16'h0001);
        hit = 0;
        for (int i = 0; i < 32 && !hit; i++) if (m_t % 16 == 9) hit = 1; else step(1);
        check("midscan_sync", 16'(hit), 16'h1);
        RST = 0;
        step(1);
        check("midscan_an", 16'(AN), 16'h000E);
        check("midscan_disp", dut.disp_val, 16'h0);
        RST = 1;
        step(20);
        foreach (sweep[i]) begin
            test_value = sweep[i];
            step(24);
            check("sweep_disp", dut.disp_val, sweep[i]);
        end
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) test_value = $urandom() & masks[$urandom_range(0, 3)];
            FREEZE = $urandom_range(0, 7) == 0;
            RST = $urandom_range(0, 59) != 0;
            step(1);
        end
        RST = 1;
        FREEZE = 0;
        step(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/test_value_display.md
# test_value_display

Four-digit multiplexed seven-segment driver that consumes the 16-bit `test_value` produced by the processor's data memory and shows it as hexadecimal on the board display. It filters transient changes with a stability hold and scans the four digits with a programmable prescaler. It provides a freeze control with a frozen indicator and optional leading-zero blanking. It sits directly downstream of the processor top level in the board wrapper.

## Interface
- `SCAN_DIV`, 50000, clock cycles each digit is driven; legal range ≥2.
- `HOLD_CYCLES`, 4, consecutive equal samples required before the displayed value updates; legal range ≥1.
- `BLANK_LZ`, 1, when 1, leading zero digits are blanked (digit 0 is never blanked).
- Clock and reset: one clock; reset is synchronous and active-low.
- `CLK`  input  1  system clock, same clock as the processor.
- `RST`  input  1  synchronous, active-low reset.
- `test_value`  input  16  value to display, taken from the data memory.
- `FREEZE`  input  1  when 1, the displayed value is held.
- `SEG`  output  7  segments in {g,f,e,d,c,b,a} order, active-low, registered.
- `DP`  output  1  decimal point, active-low, registered.
- `AN`  output  4  digit enables, active-low, registered; `AN[i]` drives nibble i (`AN[0]` is the LS nibble).

## Operation
- **Reset** (`RST`=0 at a rising edge):
  - Internal registers: `prev_val`=0, `disp_val`=0, `stab_cnt`=0, prescaler=0, `digit`=0.
  - Outputs: `AN`=4'b1110, `SEG`=7'h40, `DP`=1.
- **Stability filter.** These rules apply at every edge:
  - If `test_value`≠`prev_val`: `prev_val`←`test_value`, `stab_cnt`←0.
  - Otherwise, if `stab_cnt`<`HOLD_CYCLES`−1: `stab_cnt` increments.
  - Otherwise, `stab_cnt` saturates. If in addition `FREEZE`=0, then `disp_val`←`prev_val`.
- **Freeze.** While `FREEZE`=1, `disp_val` is held and filter tracking continues. When `FREEZE` drops, an already-stable `prev_val` loads on the next edge.
- **Scan prescaler.** The prescaler counts 0..`SCAN_DIV`−1 and wraps. At the terminal count, `digit` advances 0→1→2→3→0.
- **Digit select.** `AN` has exactly one bit low, at position `digit`, unless that digit is blanked. A blanked digit gives `AN`=4'b1111.
- **Blank rule.** Digit i (i≥1) is blanked iff `BLANK_LZ`=1 and nibbles i..3 of `disp_val` are all zero.
- **Decode.** `SEG` decodes nibble `disp_val[4*digit+3 -: 4]` to the following active-low codes:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- **Decimal point.** `DP`=0 only when `digit`=0 and `FREEZE`=1; otherwise `DP`=1.
- The block only reads `test_value`; it never drives back into the processor.

## Timing
- **Update latency.** Suppose `test_value` changes and stays stable from the sample at edge E0.
  - `prev_val` updates at E0.
  - `disp_val` updates at edge E0+`HOLD_CYCLES`.
  - `SEG`/`AN` reflect the new value at E0+`HOLD_CYCLES`+1.
  - For example, with `HOLD_CYCLES`=1 the display follows one edge after `prev_val` settles.
- **Glitch rejection.** A change lasting fewer than `HOLD_CYCLES`+1 samples never reaches `disp_val`. Any change restarts the count.
- **Digit period.** Each digit is active for exactly `SCAN_DIV` cycles; the full refresh takes 4×`SCAN_DIV` cycles.
  - `digit` changes at the terminal-count edge.
  - `AN`/`SEG` follow one edge later (output register).
- **Output register.** Outputs are registered from the current `digit` and `disp_val`, so there are no combinational paths from input to output.
- **Simultaneous events.** If `disp_val` loads on the same edge that `digit` advances, the next output cycle uses both new values.
- **Reset mid-scan.** Reset forces every register to its reset value on that edge regardless of prescaler state. Scanning restarts at digit 0 with a full `SCAN_DIV` period.
- **`FREEZE` timing.** `FREEZE` is sampled at each edge, with no latency beyond the output register.

## Test plan
All scenarios use `SCAN_DIV`=4 and `HOLD_CYCLES`=3.

1. **Reset.** Hold `RST`=0 for 2 cycles with `test_value`=16'h1234.
   - During reset: `AN`=1110, `SEG`=40, `DP`=1.
   - After release, once the value is stable: `disp_val`=1234 on the 3rd edge.
   - Scan output sequence: `AN` 1110/`SEG` 19 ("4"), 1101/30, 1011/24, 0111/79, each held 4 cycles.
2. **Glitch.** `test_value`=16'h00A5 stable, then 16'hFFFF for 2 cycles, then back to 00A5.
   - `disp_val` never becomes FFFF.
   - Digits 2 and 3 stay blanked throughout.
3. **Blanking.** `test_value`=0 → `AN` cycles 1110, 1111, 1111, 1111 with `SEG`=40 on digit 0. Repeat with `BLANK_LZ`=0 → all four digits are lit with 40.
4. **Freeze.** Display 16'hBEEF, assert `FREEZE`, apply 16'h0001 for 10 cycles.
   - Display stays BEEF; `DP`=0 on digit 0.
   - After deassert, `disp_val`=0001 on the next edge.
5. **Reset mid-scan.** Assert `RST` while `digit`=2 with the prescaler at 1.
   - Next cycle: `AN`=1110, `disp_val`=0.
   - Digit 0 lasts a full 4 cycles after release.
6. **Decoder sweep.** Present 16'h0123, 4567, 89AB, CDEF (each stable ≥8 cycles) → every nibble produces the listed `SEG` code on its digit.
